// File: rtl/knn_stream_topk.sv
// knn_stream_topk: streaming k-nearest-neighbour selector.
// Keeps a sorted K-entry list of the closest points to a latched query.
module knn_stream_topk #(
    parameter int W       = 32,
    parameter int K       = 2,
    parameter int N       = 4,
    parameter bit SIGNED  = 1'b0,
    parameter bit OUT_SEL = 1'b0,
    localparam int IW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    query,
    input  logic            pt_valid,
    input  logic [W-1:0]    pt_data,
    output logic            pt_ready,
    output logic            busy,
    output logic            done,
    output logic [W*K-1:0]  o,
    output logic [IW*K-1:0] o_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  query_q;
    logic [IW-1:0] cnt_q;

    logic [K-1:0]  vld_q;
    logic [W-1:0]  dist_q [K];
    logic [W-1:0]  pt_q   [K];
    logic [IW-1:0] idx_q  [K];

    logic          accept;
    logic          hs;
    logic          last;

    logic [W:0]    a_x;
    logic [W:0]    b_x;
    logic [W:0]    diff;
    logic [W:0]    mag;
    logic [W-1:0]  d_new;

    logic [K-1:0]  le;
    logic [K-1:0]  le_prev;
    logic [K-1:0]  ins;
    logic [K-1:0]  shf;

    logic [K-1:0]  prev_vld;
    logic [W-1:0]  prev_dist [K];
    logic [W-1:0]  prev_pt   [K];
    logic [IW-1:0] prev_idx  [K];

    assign pt_ready = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);

    assign accept = (state_q == S_IDLE) && start;
    assign hs     = pt_valid && pt_ready;
    assign last   = hs && (cnt_q == IW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (last)  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // W+1 bit difference: sign bit selects negation, magnitude always fits W bits
    always_comb begin
        a_x   = SIGNED ? {pt_data[W-1], pt_data} : {1'b0, pt_data};
        b_x   = SIGNED ? {query_q[W-1], query_q} : {1'b0, query_q};
        diff  = a_x - b_x;
        mag   = diff[W] ? (~diff + (W+1)'(1)) : diff;
        d_new = mag[W-1:0];
    end

    // le is a thermometer: valid entries are packed at the front in order
    always_comb begin
        for (int k = 0; k < K; k++) begin
            le[k] = vld_q[k] && (dist_q[k] <= d_new);
        end
    end

    assign le_prev[0]   = 1'b1;
    assign prev_vld[0]  = 1'b0;
    assign prev_dist[0] = '0;
    assign prev_pt[0]   = '0;
    assign prev_idx[0]  = '0;

    for (genvar k = 1; k < K; k++) begin : g_prev
        assign le_prev[k]   = le[k-1];
        assign prev_vld[k]  = vld_q[k-1];
        assign prev_dist[k] = dist_q[k-1];
        assign prev_pt[k]   = pt_q[k-1];
        assign prev_idx[k]  = idx_q[k-1];
    end

    assign ins = ~le & le_prev;
    assign shf = ~le & ~le_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            query_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            query_q <= query;
            cnt_q   <= '0;
        end else if (hs) begin
            cnt_q   <= cnt_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < K; k++) begin
                dist_q[k] <= '0;
                pt_q[k]   <= '0;
                idx_q[k]  <= '0;
            end
        end else if (accept) begin
            vld_q <= '0;
        end else if (hs) begin
            for (int k = 0; k < K; k++) begin
                unique case (1'b1)
                    ins[k]: begin
                        vld_q[k]  <= 1'b1;
                        dist_q[k] <= d_new;
                        pt_q[k]   <= pt_data;
                        idx_q[k]  <= cnt_q;
                    end
                    shf[k]: begin
                        vld_q[k]  <= prev_vld[k];
                        dist_q[k] <= prev_dist[k];
                        pt_q[k]   <= prev_pt[k];
                        idx_q[k]  <= prev_idx[k];
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_out
        assign o[k*W +: W]       = OUT_SEL ? pt_q[k] : dist_q[k];
        assign o_idx[k*IW +: IW] = idx_q[k];
    end

endmodule

// File: doc/knn_stream_topk.md
# knn_stream_topk

Sequential, parametrised successor to the combinational k-nearest-neighbour circuit. It latches a query value, accepts N reference points over a valid/ready stream (one per cycle max), computes each point's absolute distance to the query, and maintains a sorted K-entry list of the nearest points by parallel compare-and-shift insertion. The result is the K smallest distances, or the matching point values, plus their stream indices, held stable until the next run. It replaces the fully unrolled comb network where N is too large to flatten.

## Interface
- W, 32, bit width of query, points and distances
- K, 2, number of nearest neighbours kept; 1 <= K <= N
- N, 4, points per run; N >= 2
- SIGNED, 0, 1 = operands are two's complement; 0 = unsigned
- OUT_SEL, 0, 0 = o carries distances; 1 = o carries the original point values
- IW (derived localparam), clog2(N), index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- query  in  W  query value, latched on accepted start
- pt_valid  in  1  pt_data valid
- pt_data  in  W  reference point
- pt_ready  out  1  high only in RUN
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when results are final
- o  out  W*K  slot k at o[k*W +: W]; slot 0 = nearest
- o_idx  out  IW*K  stream index (0..N-1) of each slot, same packing

## Operation
- FSM: IDLE -> (start) RUN -> (N-th handshake) DONE -> IDLE unconditionally.
- Accepted start in IDLE latches query, clears every slot's valid flag, and clears the point counter cnt.
- Handshake = pt_valid && pt_ready. Each handshake: d = |pt_data - query_q|, evaluated signed or unsigned per SIGNED. Result is a W-bit unsigned magnitude; the signed case is computed in W+1 bits, so the magnitude fits and never wraps. A slot stores {valid, dist, point, idx=cnt}; then cnt increments.
- Insertion position p = number of valid slots whose dist <= d. Equal distances go after the existing entry: the earlier index wins ties.
- If p < K: slots p..K-2 shift to p+1..K-1, the new entry goes in slot p, and slot K-1's old content is dropped. If p == K the point is discarded.
- An invalid slot never blocks insertion, whatever its stale dist.
- cnt == N-1 on a handshake -> DONE after this insertion.
- o and o_idx are driven from the slot registers. Their contents are meaningful from the done pulse until the next accepted start; during RUN they show partial results.
- start in RUN or DONE is ignored. pt_valid outside RUN is ignored and not consumed.

## Timing
- Reset values: state = IDLE, pt_ready = 0, busy = 0, done = 0, o = 0, o_idx = 0, all slot valid flags = 0, cnt = 0, query_q = 0.
- start accepted at edge t: RUN, busy and pt_ready are high in cycle t+1.
- Throughput is one point per cycle. pt_valid gaps stall without side effects.
- The N-th handshake at edge e completes the final insertion at e. done is high for exactly the cycle after e (state DONE); pt_ready and busy are low from that cycle. IDLE follows at e+1 and a new start is accepted from then.
- Minimum run = N+2 cycles from start to IDLE.
- rst_n low at any time, including mid-RUN or during DONE: immediate return to reset values with no done pulse. A run interrupted by reset is lost.
- The comparator and shift logic are single-cycle: K parallel W-bit comparators feed a K-wide thermometer that controls the slot muxes.

## Test plan
- Basic, W=8 K=2 N=4 unsigned, query=10, points 12,7,30,11 -> done; slot0 dist=1 idx=3, slot1 dist=2 idx=0. With OUT_SEL=1, o slots = 11,12.
- Ties, query=10, points 8,12,10,9 -> slot0 dist=0 idx=2, slot1 dist=1 idx=3. Repeat with points 8,12,20,30 -> slot0 idx=0, slot1 idx=1 (both dist 2).
- Signed, SIGNED=1 W=8, query=-3 (0xFD), points 120,-128,-2,5 -> slot0 dist=1 idx=2, slot1 dist=8 idx=3. The -128 point gives dist 125 with no wrap.
- Backpressure and bounds, pt_valid toggled randomly and extra pt_valid after the N-th point -> exactly N consumed, done once, pt_ready low after. start pulsed during RUN -> ignored. K=N=4 -> all four sorted ascending.
- Reset mid-run, rst_n low after 2 handshakes -> all outputs 0 and no done. A new run with query=0, points 5,1,9,3 -> slot0 dist=1 idx=1, slot1 dist=3 idx=3.
- Back-to-back, start asserted the cycle after done -> accepted. Second run results are independent of the first, with no stale slots leaking.
